// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared SHA-3 core constants and sequencer state encoding
package sha3_pkg;

  localparam int NR_MAX = 24;
  localparam int IDX_W  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/onehot_chk.sv
// rtl/onehot_chk.sv - combinational one-hot / all-zero detector for the round index
module onehot_chk
  import sha3_pkg::*;
(
  input  logic [IDX_W-1:0] i_vec,
  output logic             o_onehot,
  output logic             o_zero
);

  logic [IDX_W-1:0] w_vec_m1;

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign w_vec_m1 = i_vec - IDX_W'(1);
  assign o_zero   = (i_vec == '0);
  assign o_onehot = !o_zero && ((i_vec & w_vec_m1) == '0);

endmodule

// File: rtl/round_seq.sv
// rtl/round_seq.sv - Keccak-f round sequencer; ROUND_SEQ_ONEHOT_CHK_EN adds the index integrity check
module round_seq
  import sha3_pkg::*;
#(
  parameter int NR = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             ack,
  output logic [IDX_W-1:0] round_idx,
  output logic             round_en,
  output logic             first,
  output logic             busy,
  output logic             done,
  input  logic             out_ack,
  output logic             err
);

  seq_state_e       r_state;
  logic [IDX_W-1:0] r_round_idx;
  logic             r_ack;
  logic             w_last;

  assign w_last = r_round_idx[NR-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_round_idx <= '0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_round_idx <= IDX_W'(1);
            r_ack       <= 1'b1;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state     <= HOLD;
            r_round_idx <= '0;
          end else begin
            r_round_idx <= r_round_idx << 1;
          end
        end
        HOLD: begin
          // A waiting block is taken in the same edge the result is consumed.
          if (out_ack) begin
            if (start) begin
              r_state     <= RUN;
              r_round_idx <= IDX_W'(1);
              r_ack       <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_round_idx <= '0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign round_idx = r_round_idx;
  assign busy      = (r_state == RUN);
  assign round_en  = busy;
  assign first     = busy && r_round_idx[0];
  assign done      = (r_state == HOLD);

`ifdef ROUND_SEQ_ONEHOT_CHK_EN
  logic w_onehot;
  logic w_zero;
  logic r_err;

  onehot_chk u_onehot_chk (
    .i_vec    (r_round_idx),
    .o_onehot (w_onehot),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if ((r_state == RUN) ? !w_onehot : !w_zero) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
